// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS keypad entry / countdown timer.
// Define TIMER_MIN_TENS_EN to add a fourth (minute tens) digit.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam bcd_t BCD_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_WRAP = 4'd5;

`ifdef TIMER_MIN_TENS_EN
    localparam int NUM_DIGITS = 4;
`else
    localparam int NUM_DIGITS = 3;
`endif

    function automatic logic bcd_valid(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/timer_digit_loader_if.sv
// Keypad, control and display bundle between the timer and its environment.
// TIMER_MIN_TENS_EN adds the min_tens display digit.
interface timer_digit_loader_if;
    import timer_pkg::*;

    bcd_t d_in;
    logic loadn;
    logic start;
    logic pause;
    logic cancel;
    logic tick;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;
`ifdef TIMER_MIN_TENS_EN
    bcd_t min_tens;
`endif
    logic running;
    logic done;

    modport master (
        output d_in, loadn, start, pause, cancel, tick,
`ifdef TIMER_MIN_TENS_EN
        input  min_tens,
`endif
        input  sec_ones, sec_tens, min_ones, running, done
    );

    modport slave (
        input  d_in, loadn, start, pause, cancel, tick,
`ifdef TIMER_MIN_TENS_EN
        output min_tens,
`endif
        output sec_ones, sec_tens, min_ones, running, done
    );

endinterface

// File: rtl/timer_bcd_digit.sv
// One BCD digit of the entry register: clear, shift-load, or decrement with
// wrap; borrow_out requests a decrement from the next more-significant digit.
module timer_bcd_digit
    import timer_pkg::*;
(
    input  logic clk,
    input  logic clearn,
    input  logic clr,
    input  logic load,
    input  bcd_t shift_in,
    input  logic dec_en,
    input  bcd_t wrap,
    output bcd_t digit,
    output logic borrow_out
);

    bcd_t digit_reg;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            digit_reg <= '0;
        end else if (clr) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= shift_in;
        end else if (dec_en) begin
            digit_reg <= (digit_reg == 4'd0) ? wrap : digit_reg - 4'd1;
        end
    end

    assign digit      = digit_reg;
    assign borrow_out = dec_en && (digit_reg == 4'd0);

endmodule

// File: rtl/timer_digit_loader.sv
// Keypad digit capture into an MM:SS BCD register and run/pause/cancel countdown.
// TIMER_MIN_TENS_EN extends the register with a minute-tens digit.
module timer_digit_loader
    import timer_pkg::*;
(
    input logic clk,
    input logic clearn,
    timer_digit_loader_if.slave bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_PAUSED = PAUSED;
    localparam logic [1:0] S_DONE   = DONE;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic                  loadn_reg;
    logic                  running_reg;
    logic                  done_reg;
    bcd_t                  digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] borrow;
    logic                  unused_borrow;
    logic                  upper_zero;
    logic                  entry_zero;
    logic                  at_one;
    logic                  do_tick;
    logic                  do_capture;

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (digit_q[i] != 4'd0) upper_zero = 1'b0;
        end
    end

    // 0:01 is the only entry whose decrement lands on zero.
    assign entry_zero = upper_zero && (digit_q[0] == 4'd0);
    assign at_one     = upper_zero && (digit_q[0] == 4'd1);

    assign do_tick    = (state_reg == S_RUN) && bus.tick && !bus.cancel && !bus.pause;
    assign do_capture = (state_reg == S_IDLE) && loadn_reg && !bus.loadn
                        && bcd_valid(bus.d_in) && !bus.cancel && !bus.start;

    always_comb begin
        state_next = state_reg;
        if (bus.cancel) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:   if (bus.start && !entry_zero) state_next = S_RUN;
                S_RUN: begin
                    if (bus.pause)             state_next = S_PAUSED;
                    else if (do_tick && at_one) state_next = S_DONE;
                end
                S_PAUSED: if (bus.start) state_next = S_RUN;
                S_DONE:   state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_reg   <= S_IDLE;
            loadn_reg   <= 1'b1;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            loadn_reg   <= bus.loadn;
            running_reg <= (state_next == S_RUN);
            done_reg    <= (state_next == S_DONE);
        end
    end

    // Digit 0 is sec_ones; the shift chain and the borrow chain both run upward.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_t shift_in;
            logic dec_en;
            if (gi == 0) begin : g_lsd
                assign shift_in = bus.d_in;
                assign dec_en   = do_tick;
            end else begin : g_chain
                assign shift_in = digit_q[gi-1];
                assign dec_en   = borrow[gi-1];
            end
            timer_bcd_digit u_digit (
                .clk        (clk),
                .clearn     (clearn),
                .clr        (bus.cancel),
                .load       (do_capture),
                .shift_in   (shift_in),
                .dec_en     (dec_en),
                .wrap       ((gi == 1) ? SEC_TENS_WRAP : BCD_MAX),
                .digit      (digit_q[gi]),
                .borrow_out (borrow[gi])
            );
        end
    endgenerate

    assign unused_borrow = borrow[NUM_DIGITS-1];

    assign bus.sec_ones = digit_q[0];
    assign bus.sec_tens = digit_q[1];
    assign bus.min_ones = digit_q[2];
`ifdef TIMER_MIN_TENS_EN
    assign bus.min_tens = digit_q[3];
`endif
    assign bus.running  = running_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_timer_digit_loader.sv
// Scoreboard bench for timer_digit_loader: expected outputs are queued as
// stimulus is driven and compared one cycle later after each rising edge.
module tb_timer_digit_loader;

    logic clk;
    logic clearn;
    int   errors;
    int   checks;

    typedef struct {
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic       run;
        logic       dn;
        string      tag;
    } exp_t;

    exp_t sb[$];

    timer_digit_loader_if bus ();

    timer_digit_loader dut (
        .clk    (clk),
        .clearn (clearn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running=%0b required finish", bus.running);
        $fatal(1, "timeout");
    end

    // Scoreboard consumer: one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks += 3;
                if ({bus.min_ones, bus.sec_tens, bus.sec_ones} !== {e.mo, e.st, e.so}) begin
                    errors++;
                    $display("FAIL %s digits: got %0d:%0d%0d required %0d:%0d%0d", e.tag,
                             bus.min_ones, bus.sec_tens, bus.sec_ones, e.mo, e.st, e.so);
                end
                if (bus.running !== e.run) begin
                    errors++;
                    $display("FAIL %s running: got %0b required %0b", e.tag, bus.running, e.run);
                end
                if (bus.done !== e.dn) begin
                    errors++;
                    $display("FAIL %s done: got %0b required %0b", e.tag, bus.done, e.dn);
                end
                $display("txn %-10s digits=%0d:%0d%0d running=%0b done=%0b", e.tag,
                         bus.min_ones, bus.sec_tens, bus.sec_ones, bus.running, bus.done);
            end
        end
    end

    task automatic push(input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so,
                        input logic run, input logic dn, input string tag);
        exp_t e;
        e.mo = mo; e.st = st; e.so = so; e.run = run; e.dn = dn; e.tag = tag;
        sb.push_back(e);
    endtask

    // Inputs change 2 time units after the edge; the scoreboard samples at +1.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic key(input logic [3:0] v, input logic [3:0] mo, input logic [3:0] st,
                       input logic [3:0] so);
        bus.d_in  = v;
        bus.loadn = 1'b0;
        push(mo, st, so, 1'b0, 1'b0, "key");
        step();
        bus.loadn = 1'b1;
        push(mo, st, so, 1'b0, 1'b0, "key_rel");
        step();
    endtask

    task automatic test_reset();
        clearn = 1'b0;
        bus.d_in = 4'd0; bus.loadn = 1'b1; bus.start = 1'b0;
        bus.pause = 1'b0; bus.cancel = 1'b0; bus.tick = 1'b0;
        step();
        step();
        checks += 2;
        if ({bus.min_ones, bus.sec_tens, bus.sec_ones} !== 12'h000) begin
            errors++;
            $display("FAIL reset_digits: got %03h required 000", {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
        if ({bus.running, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %02b required 00", {bus.running, bus.done});
        end
        $display("txn reset      checked");
        clearn = 1'b1;
        step();
    endtask

    task automatic test_capture();
        key(4'd1, 4'd0, 4'd0, 4'd1);
        key(4'd3, 4'd0, 4'd1, 4'd3);
        key(4'd0, 4'd1, 4'd3, 4'd0);
    endtask

    task automatic test_invalid_and_hold();
        key(4'd12, 4'd1, 4'd3, 4'd0);
        bus.d_in  = 4'd5;
        bus.loadn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push(4'd3, 4'd0, 4'd5, 1'b0, 1'b0, "hold");
            step();
        end
        bus.loadn = 1'b1;
        bus.cancel = 1'b1;
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "clear");
        step();
        bus.cancel = 1'b0;
    endtask

    task automatic test_countdown();
        int secs;
        key(4'd1, 4'd0, 4'd0, 4'd1);
        key(4'd0, 4'd0, 4'd1, 4'd0);
        key(4'd0, 4'd1, 4'd0, 4'd0);
        bus.start = 1'b1;
        push(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, "start");
        step();
        bus.start = 1'b0;
        secs = 60;
        while (secs > 0) begin
            secs--;
            bus.tick = 1'b1;
            push(4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10), secs != 0, secs == 0, "tick");
            step();
            bus.tick = 1'b0;
            push(4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10), secs != 0, 1'b0, "gap");
            step();
        end
    endtask

    task automatic test_pause();
        key(4'd2, 4'd0, 4'd0, 4'd2);
        bus.start = 1'b1;
        push(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, "start");
        step();
        bus.start = 1'b0; bus.pause = 1'b1; bus.tick = 1'b1;
        push(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, "pause_tick");
        step();
        bus.pause = 1'b0; bus.tick = 1'b0;
        push(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, "paused");
        step();
        bus.start = 1'b1;
        push(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, "resume");
        step();
        bus.start = 1'b0; bus.tick = 1'b1;
        push(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, "tick");
        step();
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "tick_zero");
        step();
        bus.tick = 1'b0;
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "after_done");
        step();
    endtask

    task automatic test_run_ignore_and_cancel();
        key(4'd4, 4'd0, 4'd0, 4'd4);
        key(4'd5, 4'd0, 4'd4, 4'd5);
        bus.start = 1'b1;
        push(4'd0, 4'd4, 4'd5, 1'b1, 1'b0, "start");
        step();
        bus.start = 1'b0; bus.d_in = 4'd7; bus.loadn = 1'b0;
        push(4'd0, 4'd4, 4'd5, 1'b1, 1'b0, "run_key");
        step();
        bus.loadn = 1'b1;
        push(4'd0, 4'd4, 4'd5, 1'b1, 1'b0, "run_rel");
        step();
        bus.cancel = 1'b1; bus.tick = 1'b1;
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "cancel");
        step();
        bus.cancel = 1'b0; bus.tick = 1'b0;
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "idle");
        step();
    endtask

    task automatic test_zero_start_and_clearn();
        bus.start = 1'b1;
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "zero_start");
        step();
        bus.start = 1'b0;
        push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "zero_idle");
        step();
        key(4'd3, 4'd0, 4'd0, 4'd3);
        key(4'd0, 4'd0, 4'd3, 4'd0);
        bus.start = 1'b1;
        push(4'd0, 4'd3, 4'd0, 1'b1, 1'b0, "start");
        step();
        bus.start = 1'b0; bus.tick = 1'b1;
        push(4'd0, 4'd2, 4'd9, 1'b1, 1'b0, "tick");
        step();
        clearn = 1'b0;
        #1;
        checks += 2;
        if ({bus.min_ones, bus.sec_tens, bus.sec_ones} !== 12'h000) begin
            errors++;
            $display("FAIL clearn_digits: got %03h required 000", {bus.min_ones, bus.sec_tens, bus.sec_ones});
        end
        if ({bus.running, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL clearn_flags: got %02b required 00", {bus.running, bus.done});
        end
        $display("txn clearn     checked");
        step();
        clearn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "post_clr");
            step();
        end
        bus.tick = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_capture();
        test_invalid_and_hold();
        test_countdown();
        test_pause();
        test_run_ignore_and_cancel();
        test_zero_start_and_clearn();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
